// File: rtl/mux_sched_pkg.sv
// Shared types and sizing for the round-robin mux select scheduler.
// Sizing matches a 16-input mux with a 4-bit select.
package mux_sched_pkg;

  localparam int N     = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SCAN  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between requesters/downstream (master) and the scheduler (slave).
// sel/gnt/valid are registered outputs of the scheduler.
interface mux_rr_scheduler_if #(
  parameter int N     = mux_sched_pkg::N,
  parameter int SEL_W = mux_sched_pkg::SEL_W
);

  logic [N-1:0]     req;
  logic             mode;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     gnt;
  logic             valid;

  modport master (
    output req,
    output mode,
    output ready,
    input  sel,
    input  gnt,
    input  valid
  );

  modport slave (
    input  req,
    input  mode,
    input  ready,
    output sel,
    output gnt,
    output valid
  );

endinterface

// File: rtl/mux_rr_pick.sv
// Rotating-priority search: first set req bit after 'last', wrapping; last itself is lowest priority.
// Purely combinational; requires N == 2**SEL_W so the index wraps naturally.
module mux_rr_pick #(
  parameter int N     = mux_sched_pkg::N,
  parameter int SEL_W = mux_sched_pkg::SEL_W
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester after 'last' overwrites.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    cand   = '0;
    for (int k = N; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Drives the select of a 16:1 mux: round-robin over req, or a free-running sweep in scan mode.
// 1-cycle grant latency from IDLE; one transfer per cycle when ready=1; outputs hold while ready=0.
module mux_rr_scheduler #(
  parameter int N     = mux_sched_pkg::N,
  parameter int SEL_W = mux_sched_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  mux_rr_scheduler_if.slave bus
);

  import mux_sched_pkg::*;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic [SEL_W-1:0] pick_last;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic [SEL_W-1:0] sel_inc;

  // A GRANT transfer moves last to sel on this edge, so search from sel for back-to-back grants.
  assign pick_last = (state_q == GRANT) ? sel_q : last_q;
  assign sel_inc   = sel_q + SEL_W'(1);

  mux_rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req    (bus.req),
    .last   (pick_last),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.mode) begin
          state_d = SCAN;
          sel_d   = '0;
          gnt_d   = N'(1);
          valid_d = 1'b1;
        end else if (any) begin
          state_d = GRANT;
          sel_d   = winner;
          gnt_d   = N'(1) << winner;
          valid_d = 1'b1;
        end else begin
          gnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (bus.ready) begin
          last_d = sel_q;
          if (any) begin
            sel_d = winner;
            gnt_d = N'(1) << winner;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (bus.ready) begin
          last_d = sel_q;
          sel_d  = sel_inc;
          if (sel_q == SEL_W'(N-1) && !bus.mode) begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
          end else begin
            gnt_d = N'(1) << sel_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SEL_W'(N-1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.gnt   = gnt_q;
  assign bus.valid = valid_q;

endmodule
